// File: rtl/div_iter_unit_if.sv
// Decode -> execute divider interface.
// master: issuing side (start_i, signed_i, dividend_i, divisor_i, annul_i out; status/result in).
// slave : divider side (request in; busy_o, ready_o, lo_o, hi_o, dbz_o out).
interface div_iter_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             annul_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] hi_o;
  logic             dbz_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  busy_o, ready_o, lo_o, hi_o, dbz_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output busy_o, ready_o, lo_o, hi_o, dbz_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider producing quotient (LO) and remainder (HI).
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset
//   bus     - div_iter_unit_if.slave: start/signed/operands/annul in;
//             busy (stall request), ready pulse, lo/hi result and divide-by-zero flag out.
// One quotient bit per cycle on magnitudes; signs are applied when the result is presented.
module div_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           resetn,
  div_iter_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_op_q, dbz_op_d;
  logic             dbz_q, dbz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             accept, present;

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which is correct as an unsigned value.
  always_comb begin
    dvd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
    dvs_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
    abs_dvd = dvd_neg ? -bus.dividend_i : bus.dividend_i;
    abs_dvs = dvs_neg ? -bus.divisor_i : bus.divisor_i;
  end

  // One restoring step: partial remainder needs WIDTH+1 bits before the trial subtract.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
  end

  // Final signed result; for divide-by-zero rem_q holds the raw dividend.
  always_comb begin
    if (dbz_op_q) begin
      res_lo = '1;
      res_hi = rem_q;
    end else begin
      res_lo = neg_quo_q ? -quo_q : quo_q;
      res_hi = neg_rem_q ? -rem_q : rem_q;
    end
  end

  assign accept  = (state_q == StIdle) && bus.start_i && !bus.annul_i;
  // An annul in the DONE cycle squashes both the pulse and the result update.
  assign present = (state_q == StDone) && !bus.annul_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_op_d  = dbz_op_q;
    dbz_d     = dbz_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          if (bus.divisor_i == '0) begin
            dbz_op_d = 1'b1;
            rem_d    = bus.dividend_i;
            state_d  = StDone;
          end else begin
            dbz_op_d = 1'b0;
            rem_d    = '0;
            quo_d    = abs_dvd;
            dvsr_d   = abs_dvs;
            cnt_d    = CntW'(WIDTH - 1);
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.annul_i) begin
          state_d = StIdle;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (present) begin
          lo_d  = res_lo;
          hi_d  = res_hi;
          dbz_d = dbz_op_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_op_q  <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_op_q  <= dbz_op_d;
      dbz_q     <= dbz_d;
    end
  end

  // Result is visible during the ready cycle itself, then held in lo_q/hi_q.
  always_comb begin
    bus.busy_o  = (state_q == StCalc) || (state_q == StDone);
    bus.ready_o = present;
    bus.lo_o    = present ? res_lo : lo_q;
    bus.hi_o    = present ? res_hi : hi_q;
    bus.dbz_o   = present ? dbz_op_q : dbz_q;
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: a cycle-level reference model (arithmetic division plus
// a latency counter) is compared against busy/ready/lo/hi/dbz on every falling edge, plus
// directed literal checks for the documented cases.
module tb_div_iter_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  div_iter_unit_if #(.WIDTH(W)) bus ();
  div_iter_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference division from arithmetic: returns {dbz, hi, lo}.
  function automatic logic [64:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {1'b0, rv[31:0], qv[31:0]};
  endfunction

  // Timing model: accepted op becomes visible m_target cycles after the accept edge.
  logic        m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_target = 0;
  logic [31:0] m_lo = '0, m_hi = '0, r_lo = '0, r_hi = '0;
  logic        m_dbz = 1'b0, r_dbz = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
      m_lo   <= '0;
      m_hi   <= '0;
      m_dbz  <= 1'b0;
    end else if (!m_busy) begin
      if (bus.start_i && !bus.annul_i) begin
        m_busy   <= 1'b1;
        m_cyc    <= 1;
        m_target <= (bus.divisor_i == 32'd0) ? 1 : W + 1;
        {r_dbz, r_hi, r_lo} <= ref_div(bus.signed_i, bus.dividend_i, bus.divisor_i);
      end
    end else if (bus.annul_i) begin
      m_busy <= 1'b0;
    end else if (m_cyc == m_target) begin
      m_busy <= 1'b0;
      m_lo   <= r_lo;
      m_hi   <= r_hi;
      m_dbz  <= r_dbz;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  logic exp_ready;
  always @(negedge clk) begin
    exp_ready = m_busy && (m_cyc == m_target) && !bus.annul_i;
    check("busy_o", 64'(bus.busy_o), 64'(m_busy));
    check("ready_o", 64'(bus.ready_o), 64'(exp_ready));
    check("lo_o", 64'(bus.lo_o), 64'(exp_ready ? r_lo : m_lo));
    check("hi_o", 64'(bus.hi_o), 64'(exp_ready ? r_hi : m_hi));
    check("dbz_o", 64'(bus.dbz_o), 64'(exp_ready ? r_dbz : m_dbz));
  end

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic chk, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edbz, input string tag);
    int   lat;
    logic seen;
    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk); #1;
    // Operands may change freely after the accept edge.
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'($urandom);
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.ready_o) seen = 1'b1;
    end
    check({tag, " ready seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'(W + 1));
      if (chk) begin
        check({tag, " lo"}, 64'(bus.lo_o), 64'(elo));
        check({tag, " hi"}, 64'(bus.hi_o), 64'(ehi));
        check({tag, " dbz"}, 64'(bus.dbz_o), 64'(edbz));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    int          k;
    logic        sgn;
    logic [31:0] a, b;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.annul_i    = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset lo", 64'(bus.lo_o), 64'd0);
    check("reset hi", 64'(bus.hi_o), 64'd0);
    check("reset dbz", 64'(bus.dbz_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Pin the reference model to hand-computed values.
    check("model divu 100/7", 64'(ref_div(1'b0, 32'd100, 32'd7)), {31'd0, 1'b0, 32'd2, 32'd14});
    check("model div -7/2 lo", 64'(ref_div(1'b1, 32'hFFFF_FFF9, 32'd2) & 65'hFFFF_FFFF),
          64'hFFFF_FFFD);
    check("model div 7/-2 hi", 64'(ref_div(1'b1, 32'd7, 32'hFFFF_FFFE) >> 32), 64'h1);
    check("model div min/-1", 64'(ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF)),
          64'h0000_0000_8000_0000);
    check("model dbz", 64'(ref_div(1'b0, 32'h1234, 32'd0) >> 32), 64'h1_0000_1234);

    do_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, "divu 100/7");
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div -7/2");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "div min/-1");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "divu min/max");
    do_op(1'b0, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, "dbz");
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, "div 7/-2");

    // Annul during cycle 10 of a 100/7: no pulse, previous result kept.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) pulses++;
    end
    check("annul no ready", 64'(pulses), 64'd0);
    check("annul busy low", 64'(bus.busy_o), 64'd0);
    check("annul lo kept", 64'(bus.lo_o), 64'hFFFF_FFFD);
    check("annul hi kept", 64'(bus.hi_o), 64'd1);

    // start together with annul in IDLE is ignored.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    @(negedge clk);
    check("start+annul ignored", 64'(bus.busy_o), 64'd0);

    do_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, "after annul");
    do_op(1'b1, 32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, "back-to-back");

    // Async reset mid-CALC clears everything without waiting for an edge.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("midreset busy", 64'(bus.busy_o), 64'd0);
    check("midreset ready", 64'(bus.ready_o), 64'd0);
    check("midreset lo", 64'(bus.lo_o), 64'd0);
    check("midreset hi", 64'(bus.hi_o), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // start_i held through the busy window: only the first request completes.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    @(posedge clk);
    k = 0;
    pulses = 0;
    while (pulses == 0 && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.ready_o) pulses++;
    end
    check("held start first latency", 64'(k), 64'(W + 1));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) pulses++;
    end
    check("held start single pulse", 64'(pulses), 64'd1);

    // Randomized operations, values checked by the per-cycle compare process.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      k   = int'($urandom_range(0, 7));
      a   = $urandom;
      case (k)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(sgn, a, b, 1'b0, 32'd0, 32'd0, 1'b0, "random");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
